// File: rtl/pong_pkg.sv
// Shared Pong definitions: game state encoding, default sizing and a
// saturating score helper used by the ball, paddle and score blocks.
package pong_pkg;

  localparam int STATE_WIDTH      = 3;
  localparam int SCORE_WIDTH_DEF  = 4;
  localparam int WIN_SCORE_DEF    = 7;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int CNT_WIDTH_DEF    = 8;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // A point never pushes a score past the winning total.
  function automatic int sat_inc(input int value, input int limit);
    return (value >= limit) ? limit : value + 1;
  endfunction

endpackage

// File: rtl/game_sequencer_rise_detect.sv
// Rising-edge detector for a level input; history resets high so a button
// already held when reset releases is not seen as a press.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/game_sequencer.sv
// Pong game sequencer: serve hold-off, rally, point scoring and game-over
// control, with every output registered off the next-state decision.
module game_sequencer
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int SCORE_WIDTH  = SCORE_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_frame_tick,
  input  logic                   i_start,
  input  logic                   i_miss_left,
  input  logic                   i_miss_right,
  output logic                   o_ball_reset,
  output logic                   o_ball_enable,
  output logic                   o_serve_dir,
  output logic [SCORE_WIDTH-1:0] o_score1,
  output logic [SCORE_WIDTH-1:0] o_score2,
  output logic                   o_game_over,
  output logic                   o_winner,
  output logic [STATE_WIDTH-1:0] o_state
);

  localparam logic [SCORE_WIDTH-1:0] WIN_S      = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [CNT_WIDTH-1:0]   SERVE_LOAD = CNT_WIDTH'(SERVE_FRAMES);

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [SCORE_WIDTH-1:0] r_score1;
  logic [SCORE_WIDTH-1:0] r_score2;
  logic                   r_serve_dir;
  logic                   r_ball_reset;
  logic                   r_ball_enable;
  logic                   r_game_over;
  logic                   r_winner;

  state_t                 w_state_next;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic [SCORE_WIDTH-1:0] w_score1_next;
  logic [SCORE_WIDTH-1:0] w_score2_next;
  logic                   w_serve_dir_next;
  logic                   w_serve_entry;
  logic                   w_win_reached;
  logic                   w_start_rise;

  rise_detect u_start_rise (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_start),
    .o_rise (w_start_rise)
  );

  assign w_win_reached = (r_score1 == WIN_S) || (r_score2 == WIN_S);

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_score1_next    = r_score1;
    w_score2_next    = r_score2;
    w_serve_dir_next = r_serve_dir;

    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state_next     = ST_SERVE;
          w_serve_dir_next = 1'b0;
          w_score1_next    = '0;
          w_score2_next    = '0;
        end
      end

      ST_SERVE: begin
        if (i_frame_tick) begin
          if (r_cnt == '0) begin
            w_state_next = ST_PLAY;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
      end

      ST_PLAY: begin
        // A double miss is a let: nobody scores, the serve swaps sides.
        if (i_miss_left && i_miss_right) begin
          w_serve_dir_next = ~r_serve_dir;
          w_state_next     = ST_POINT;
        end else if (i_miss_right) begin
          w_score1_next    = SCORE_WIDTH'(sat_inc(int'(r_score1), WIN_SCORE));
          w_serve_dir_next = 1'b1;
          w_state_next     = ST_POINT;
        end else if (i_miss_left) begin
          w_score2_next    = SCORE_WIDTH'(sat_inc(int'(r_score2), WIN_SCORE));
          w_serve_dir_next = 1'b0;
          w_state_next     = ST_POINT;
        end
      end

      ST_POINT: begin
        if (i_frame_tick) begin
          w_state_next = w_win_reached ? ST_OVER : ST_SERVE;
        end
      end

      ST_OVER: begin
        if (w_start_rise) begin
          w_state_next     = ST_SERVE;
          w_serve_dir_next = 1'b0;
          w_score1_next    = '0;
          w_score2_next    = '0;
        end
      end

      default: begin
        w_state_next     = ST_IDLE;
        w_serve_dir_next = 1'b0;
        w_score1_next    = '0;
        w_score2_next    = '0;
      end
    endcase

    // Every fresh serve restarts the hold-off, whichever state it came from.
    w_serve_entry = (w_state_next == ST_SERVE) && (r_state != ST_SERVE);
    if (w_serve_entry) begin
      w_cnt_next = SERVE_LOAD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_score1      <= '0;
      r_score2      <= '0;
      r_serve_dir   <= 1'b0;
      r_ball_reset  <= 1'b0;
      r_ball_enable <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_score1      <= w_score1_next;
      r_score2      <= w_score2_next;
      r_serve_dir   <= w_serve_dir_next;
      r_ball_reset  <= w_serve_entry;
      r_ball_enable <= (w_state_next == ST_PLAY);
      r_game_over   <= (w_state_next == ST_OVER);
      r_winner      <= (w_state_next == ST_OVER) && (w_score2_next == WIN_S);
    end
  end

  assign o_ball_reset  = r_ball_reset;
  assign o_ball_enable = r_ball_enable;
  assign o_serve_dir   = r_serve_dir;
  assign o_score1      = r_score1;
  assign o_score2      = r_score2;
  assign o_game_over   = r_game_over;
  assign o_winner      = r_winner;
  assign o_state       = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a vector table and hand sequences on two
// parameterisations, plus random play against a rule-level model.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic start = 1'b0;
  logic miss_left = 1'b0;
  logic miss_right = 1'b0;

  always #5 clk = ~clk;

  // Instance A: short serve, game to 2. Instance B: immediate serve, game to 7.
  logic       a_br, a_be, a_dir, a_go, a_win;
  logic [3:0] a_s1, a_s2;
  logic [2:0] a_state;
  logic       b_br, b_be, b_dir, b_go, b_win;
  logic [3:0] b_s1, b_s2;
  logic [2:0] b_state;

  game_sequencer #(.SERVE_FRAMES(3), .WIN_SCORE(2), .SCORE_WIDTH(4), .CNT_WIDTH(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(frame_tick), .i_start(start),
    .i_miss_left(miss_left), .i_miss_right(miss_right),
    .o_ball_reset(a_br), .o_ball_enable(a_be), .o_serve_dir(a_dir),
    .o_score1(a_s1), .o_score2(a_s2), .o_game_over(a_go), .o_winner(a_win),
    .o_state(a_state)
  );

  game_sequencer #(.SERVE_FRAMES(0), .WIN_SCORE(7), .SCORE_WIDTH(4), .CNT_WIDTH(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(frame_tick), .i_start(start),
    .i_miss_left(miss_left), .i_miss_right(miss_right),
    .o_ball_reset(b_br), .o_ball_enable(b_be), .o_serve_dir(b_dir),
    .o_score1(b_s1), .o_score2(b_s2), .o_game_over(b_go), .o_winner(b_win),
    .o_state(b_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_cycle = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, n_cycle, act, exp);
    end
  endtask

  // Reference model: the game described as phases and tick counts.
  int m_sf[2]  = '{3, 0};
  int m_win[2] = '{2, 7};
  int m_phase[2], m_s1[2], m_s2[2], m_dir[2], m_ticks[2], m_prev[2], m_br[2];

  task automatic model_step(input int k);
    int  old_phase;
    bit  rise;
    if (!rst) begin
      m_phase[k] = 0; m_s1[k] = 0; m_s2[k] = 0; m_dir[k] = 0;
      m_ticks[k] = 0; m_prev[k] = 1; m_br[k] = 0;
      return;
    end
    rise = start && (m_prev[k] == 0);
    m_prev[k] = int'(start);
    old_phase = m_phase[k];
    case (m_phase[k])
      0: if (rise) begin m_phase[k] = 1; m_dir[k] = 0; m_s1[k] = 0; m_s2[k] = 0; end
      1: if (frame_tick) begin
           if (m_ticks[k] == m_sf[k]) m_phase[k] = 2;
           else m_ticks[k]++;
         end
      2: begin
           if (miss_left && miss_right) begin
             m_dir[k] = 1 - m_dir[k]; m_phase[k] = 3;
           end else if (miss_right) begin
             m_s1[k] = (m_s1[k] + 1 > m_win[k]) ? m_win[k] : m_s1[k] + 1;
             m_dir[k] = 1; m_phase[k] = 3;
           end else if (miss_left) begin
             m_s2[k] = (m_s2[k] + 1 > m_win[k]) ? m_win[k] : m_s2[k] + 1;
             m_dir[k] = 0; m_phase[k] = 3;
           end
         end
      3: if (frame_tick)
           m_phase[k] = (m_s1[k] == m_win[k] || m_s2[k] == m_win[k]) ? 4 : 1;
      default: if (rise) begin m_phase[k] = 1; m_dir[k] = 0; m_s1[k] = 0; m_s2[k] = 0; end
    endcase
    m_br[k] = (m_phase[k] == 1 && old_phase != 1) ? 1 : 0;
    if (m_br[k] == 1) m_ticks[k] = 0;
  endtask

  task automatic compare_model(input int k);
    string p;
    p = (k == 0) ? "mdlA" : "mdlB";
    check({p, " state"}, (k == 0) ? int'(a_state) : int'(b_state), m_phase[k]);
    check({p, " score1"}, (k == 0) ? int'(a_s1) : int'(b_s1), m_s1[k]);
    check({p, " score2"}, (k == 0) ? int'(a_s2) : int'(b_s2), m_s2[k]);
    check({p, " serve_dir"}, (k == 0) ? int'(a_dir) : int'(b_dir), m_dir[k]);
    check({p, " ball_reset"}, (k == 0) ? int'(a_br) : int'(b_br), m_br[k]);
    check({p, " ball_enable"}, (k == 0) ? int'(a_be) : int'(b_be), (m_phase[k] == 2) ? 1 : 0);
    check({p, " game_over"}, (k == 0) ? int'(a_go) : int'(b_go), (m_phase[k] == 4) ? 1 : 0);
    check({p, " winner"}, (k == 0) ? int'(a_win) : int'(b_win),
          (m_phase[k] == 4 && m_s2[k] == m_win[k]) ? 1 : 0);
  endtask

  // One clock: drive inputs, step the model at the edge, sample 1 ns later.
  task automatic cycle(input logic r, input logic st, input logic fl,
                       input logic ml, input logic mr);
    rst = r; start = st; frame_tick = fl; miss_left = ml; miss_right = mr;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    n_cycle++;
    compare_model(0);
    compare_model(1);
  endtask

  typedef struct {
    logic rst, st, fl, ml, mr;
    int   state, s1, s2, dir, be, br, go, win;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic st, input logic fl,
                              input logic ml, input logic mr,
                              input int state, input int s1, input int s2,
                              input int dir, input int be, input int br,
                              input int go, input int win);
    vec_t v;
    v.rst = r; v.st = st; v.fl = fl; v.ml = ml; v.mr = mr;
    v.state = state; v.s1 = s1; v.s2 = s2; v.dir = dir;
    v.be = be; v.br = br; v.go = go; v.win = win;
    return v;
  endfunction

  initial begin
    logic st_r;

    // Full game on instance A (serve 3 frames, game to 2).
    vecs.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,0,0,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,1,0,0, 1,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1, 1,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 2,0,0,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 2,0,0,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,1, 3,1,0,1,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 3,1,0,1,0,0,0,0));
    vecs.push_back(mk(1,1,1,0,0, 1,1,0,1,0,1,0,0));
    vecs.push_back(mk(1,0,0,0,0, 1,1,0,1,0,0,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,1,0,0, 1,1,0,1,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 2,1,0,1,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,1, 3,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 1,1,0,0,0,1,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,1,0,0, 1,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 2,1,0,0,1,0,0,0));
    vecs.push_back(mk(1,0,1,1,0, 3,1,1,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 1,1,1,0,0,1,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,1,0,0, 1,1,1,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 2,1,1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,0, 3,1,2,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4,1,2,0,0,0,1,1));
    vecs.push_back(mk(1,0,0,1,0, 4,1,2,0,0,0,1,1));
    vecs.push_back(mk(1,0,0,0,1, 4,1,2,0,0,0,1,1));
    vecs.push_back(mk(1,1,0,0,0, 1,0,0,0,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,0, 1,0,0,0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      cycle(v.rst, v.st, v.fl, v.ml, v.mr);
      check($sformatf("vec%0d state", i), int'(a_state), v.state);
      check($sformatf("vec%0d score1", i), int'(a_s1), v.s1);
      check($sformatf("vec%0d score2", i), int'(a_s2), v.s2);
      check($sformatf("vec%0d serve_dir", i), int'(a_dir), v.dir);
      check($sformatf("vec%0d ball_enable", i), int'(a_be), v.be);
      check($sformatf("vec%0d ball_reset", i), int'(a_br), v.br);
      check($sformatf("vec%0d game_over", i), int'(a_go), v.go);
      check($sformatf("vec%0d winner", i), int'(a_win), v.win);
      $display("[TB] vec %0d: state A=%0d B=%0d score A=%0d:%0d", i, a_state, b_state, a_s1, a_s2);
    end

    // Instance B: zero serve hold-off, build score1=3 in PLAY, then reset.
    cycle(0,0,0,0,0);
    cycle(1,0,0,0,0);
    cycle(1,1,0,0,0);
    check("B serve entry", int'(b_state), 1);
    cycle(1,1,1,0,0);
    check("B zero-hold leaves on first tick", int'(b_state), 2);
    check("B ball_enable with PLAY", int'(b_be), 1);
    check("A still serving", int'(a_state), 1);
    for (int p = 0; p < 3; p++) begin
      cycle(1,0,0,0,1);
      cycle(1,0,1,0,0);
      cycle(1,0,1,0,0);
      $display("[TB] B point %0d: score1=%0d state=%0d", p, b_s1, b_state);
    end
    check("B score1 before reset", int'(b_s1), 3);
    check("B in PLAY before reset", int'(b_state), 2);
    cycle(0,1,0,0,0);
    check("B reset state", int'(b_state), 0);
    check("B reset score1", int'(b_s1), 0);
    check("B reset ball_enable", int'(b_be), 0);
    check("B reset ball_reset", int'(b_br), 0);
    check("B reset serve_dir", int'(b_dir), 0);
    check("B reset game_over", int'(b_go), 0);
    cycle(1,1,0,0,0);
    check("B held start after reset", int'(b_state), 0);
    $display("[TB] reset sequence done: B state=%0d", b_state);

    // Random play checked against the model on both instances.
    st_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic r, fl, ml, mr;
      r  = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) st_r = ~st_r;
      fl = ($urandom_range(0, 1) == 0);
      ml = ($urandom_range(0, 6) == 0);
      mr = ($urandom_range(0, 6) == 0);
      cycle(r, st_r, fl, ml, mr);
      if (i % 500 == 0)
        $display("[TB] random %0d: A state=%0d %0d:%0d  B state=%0d %0d:%0d",
                 i, a_state, a_s1, a_s2, b_state, b_s1, b_s2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter SERVE_FRAMES, default 60: frame_tick pulses the ball is held before release in SERVE.
REQ-002 Parameter WIN_SCORE, default 7: points that end the game.
REQ-003 Parameter SCORE_WIDTH, default 4: width of each score output.
REQ-004 Parameter CNT_WIDTH, default 8: serve counter width.
REQ-005 clk  in  1  single system clock, all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 start  in  1  player start button, level; internally synchronous-edge detected.
REQ-009 miss_left  in  1  one-cycle pulse: ball passed player1 edge, point to player2.
REQ-010 miss_right  in  1  one-cycle pulse: ball passed player2 edge, point to player1.
REQ-011 ball_reset  out  1  one-cycle pulse: ball recentres at MID position.
REQ-012 ball_enable  out  1  ball and paddle motion permitted.
REQ-013 serve_dir  out  1  0 = serve toward player1, 1 = toward player2.
REQ-014 score1, score2  out  SCORE_WIDTH each  registered player scores.
REQ-015 game_over  out  1  high while in OVER.
REQ-016 winner  out  1  0 = player1, 1 = player2; valid while game_over.
REQ-017 state  out  3  current state code, debug.

Function
REQ-018 States, codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; codes 5-7 go to IDLE next cycle.
REQ-019 start_rise = start high this cycle and low previous cycle; only start_rise is acted on.
REQ-020 IDLE: ball_enable 0, scores held 0; start_rise -> SERVE, serve_dir 0.
REQ-021 Every entry into SERVE: counter loaded with SERVE_FRAMES; ball_reset high exactly the first cycle in SERVE.
REQ-022 SERVE: ball_enable 0; on frame_tick, counter==0 -> PLAY, else decrement; SERVE_FRAMES=0 -> leave on first frame_tick.
REQ-023 PLAY: ball_enable 1; miss_right alone -> score1+1, serve_dir 1; miss_left alone -> score2+1, serve_dir 0; either -> POINT.
REQ-024 PLAY, miss_left and miss_right same cycle: no score change, serve_dir toggles, -> POINT.
REQ-025 POINT: ball_enable 0; waits for next frame_tick; then any score == WIN_SCORE -> OVER, else -> SERVE.
REQ-026 OVER: game_over 1, winner = player whose score == WIN_SCORE, scores held; start_rise -> both scores 0, serve_dir 0, -> SERVE.
REQ-027 miss pulses outside PLAY are ignored; start_rise in SERVE, PLAY, POINT is ignored.
REQ-028 Scores never exceed WIN_SCORE; increment saturates at WIN_SCORE.
REQ-029 All outputs registered; state change visible one cycle after the causing input.
REQ-030 frame_tick coincident with a miss in PLAY: miss handled, tick does not advance POINT.

Reset
REQ-031 rst low at posedge: state IDLE, scores 0, counter 0, serve_dir 0, ball_reset 0, ball_enable 0, game_over 0, winner 0, start history 1 (held button not a rise).
REQ-032 Reset mid-game aborts immediately; no ball_reset pulse issued by reset itself.

Structure
REQ-033 Shared package pong_pkg holds state enum, state codes, SCORE_WIDTH and WIN_SCORE defaults; ball, paddle and score blocks import it.
REQ-034 One sub-module rise_detect (start edge detector, reset value 1); remainder a single FSM plus counter.

Verification
REQ-035 Reset, start held high through release of rst -> stays IDLE; start low then high -> SERVE next cycle, ball_reset single pulse.
REQ-036 SERVE_FRAMES=3: PLAY entered on the 4th frame_tick after SERVE entry, ball_enable rises next cycle.
REQ-037 PLAY, miss_right pulse -> score1=1, serve_dir=1, POINT; next frame_tick -> SERVE with ball_reset pulse.
REQ-038 WIN_SCORE=2, two miss_left points -> score2=2, OVER, game_over=1, winner=1; further misses leave scores unchanged.
REQ-039 PLAY, miss_left and miss_right same cycle with serve_dir=0 -> scores unchanged, serve_dir=1, POINT.
REQ-040 rst low in PLAY with score1=3 -> next cycle IDLE, all outputs at reset values.
